// File: rtl/mvm_out_requant.sv
// Requantizing output stage for the 3x3 MVM: ReLU, rounded shift, int8 saturation,
// a small result FIFO and end-of-vector tagging, with sticky overflow/saturation flags.
module mvm_out_requant #(
   parameter int VEC_LEN = 3,
   parameter int SHIFT   = 4,
   parameter int DEPTH   = 4,
   parameter bit RELU_EN = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [15:0] data_in,
   input  logic        ovf_in,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [7:0]  data_out,
   output logic        m_last,
   output logic        overflow,
   output logic        sat
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
   localparam logic signed [16:0] RND =
      (SHIFT > 0) ? (17'sd1 <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : 17'sd0;
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
   localparam logic [CW-1:0] LAST_IDX = CW'(VEC_LEN - 1);

   logic [8:0]    mem_q [DEPTH];
   logic [8:0]    mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [CW-1:0] elem_q, elem_d;
   logic          s_ready_q, s_ready_d;
   logic          overflow_q, overflow_d;
   logic          sat_q, sat_d;

   logic signed [16:0] y;
   logic signed [16:0] r;
   logic [7:0]         q8;
   logic               sat_elem;
   logic               push;
   logic               pop;
   logic               last_elem;

   // 17-bit datapath keeps 32767 + rounding constant from wrapping before the shift
   always_comb begin
      y = {data_in[15], data_in};
      if (RELU_EN && data_in[15]) begin
         y = '0;
      end
      r        = (y + RND) >>> SHIFT;
      sat_elem = 1'b0;
      q8       = r[7:0];
      if (r > 17'sd127) begin
         q8       = 8'h7f;
         sat_elem = 1'b1;
      end else if (r < -17'sd128) begin
         q8       = 8'h80;
         sat_elem = 1'b1;
      end
   end

   assign m_valid   = (cnt_q != '0);
   assign push      = s_valid && s_ready_q;
   assign pop       = m_valid && m_ready;
   assign last_elem = (elem_q == LAST_IDX);

   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      elem_d     = elem_q;
      overflow_d = overflow_q;
      sat_d      = sat_q;
      if (push) begin
         mem_d[wr_ptr_q] = {q8, last_elem};
         wr_ptr_d        = wr_ptr_q + AW'(1);
         elem_d          = last_elem ? '0 : elem_q + CW'(1);
         overflow_d      = overflow_q | ovf_in;
         sat_d           = sat_q | sat_elem;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      cnt_d     = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      s_ready_d = (cnt_d != FULL_CNT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         elem_q     <= '0;
         s_ready_q  <= 1'b1;
         overflow_q <= 1'b0;
         sat_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         elem_q     <= elem_d;
         s_ready_q  <= s_ready_d;
         overflow_q <= overflow_d;
         sat_q      <= sat_d;
      end
   end

   // Storage needs no reset: the head is masked whenever the FIFO is empty
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign s_ready  = s_ready_q;
   assign data_out = m_valid ? mem_q[rd_ptr_q][8:1] : 8'h00;
   assign m_last   = m_valid ? mem_q[rd_ptr_q][0] : 1'b0;
   assign overflow = overflow_q;
   assign sat      = sat_q;
endmodule

// File: tb/tb_mvm_out_requant.sv
// Bench for mvm_out_requant: three configurations share one stimulus stream and are
// checked against a queue-based reference model of the output stage.
module tb_mvm_out_requant;
   localparam int DEPTH   = 4;
   localparam int VEC_LEN = 3;
   localparam int NI      = 3;
   localparam int SHIFT_V [NI] = '{4, 4, 0};
   localparam bit RELU_V  [NI] = '{1'b1, 1'b0, 1'b1};

   logic        clk = 1'b0;
   logic        reset;
   logic        s_valid;
   logic        m_ready;
   logic        ovf_in;
   logic [15:0] data_in;
   logic        s_ready  [NI];
   logic        m_valid  [NI];
   logic        m_last   [NI];
   logic        overflow [NI];
   logic        sat      [NI];
   logic [7:0]  data_out [NI];

   int mq [NI][$];
   int m_cnt;
   bit m_ovf;
   bit m_sat [NI];
   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mvm_out_requant #(.VEC_LEN(3), .SHIFT(4), .DEPTH(4), .RELU_EN(1'b1)) u_a (
      .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready[0]),
      .data_in(data_in), .ovf_in(ovf_in), .m_valid(m_valid[0]), .m_ready(m_ready),
      .data_out(data_out[0]), .m_last(m_last[0]), .overflow(overflow[0]), .sat(sat[0]));
   mvm_out_requant #(.VEC_LEN(3), .SHIFT(4), .DEPTH(4), .RELU_EN(1'b0)) u_b (
      .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready[1]),
      .data_in(data_in), .ovf_in(ovf_in), .m_valid(m_valid[1]), .m_ready(m_ready),
      .data_out(data_out[1]), .m_last(m_last[1]), .overflow(overflow[1]), .sat(sat[1]));
   mvm_out_requant #(.VEC_LEN(3), .SHIFT(0), .DEPTH(4), .RELU_EN(1'b1)) u_c (
      .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready[2]),
      .data_in(data_in), .ovf_in(ovf_in), .m_valid(m_valid[2]), .m_ready(m_ready),
      .data_out(data_out[2]), .m_last(m_last[2]), .overflow(overflow[2]), .sat(sat[2]));

   // Round-half-up division by 2^sh using floor division, then clamp to int8
   function automatic int requant(input int x, input int sh, input bit relu, output bit s);
      int y, v, d, res;
      y = (relu && x < 0) ? 0 : x;
      if (sh > 0) begin
         d   = 1 << sh;
         v   = y + d / 2;
         res = (v >= 0) ? v / d : -((-v + d - 1) / d);
      end else begin
         res = y;
      end
      s = (res > 127) || (res < -128);
      if (res > 127) res = 127;
      else if (res < -128) res = -128;
      return res;
   endfunction

   // Advance the model with the currently driven inputs, then move past the next edge
   task automatic step();
      bit acc, pop, s;
      int x, res, lst;
      x   = $signed(data_in);
      acc = !reset && s_valid && (mq[0].size() < DEPTH);
      pop = !reset && m_ready && (mq[0].size() > 0);
      if (reset) begin
         for (int i = 0; i < NI; i++) begin
            mq[i].delete();
            m_sat[i] = 1'b0;
         end
         m_cnt = 0;
         m_ovf = 1'b0;
      end else begin
         lst = (m_cnt == VEC_LEN - 1) ? 256 : 0;
         for (int i = 0; i < NI; i++) begin
            if (pop) void'(mq[i].pop_front());
            if (acc) begin
               res = requant(x, SHIFT_V[i], RELU_V[i], s);
               mq[i].push_back(lst | (res & 255));
               if (s) m_sat[i] = 1'b1;
            end
         end
         if (acc) begin
            if (ovf_in) m_ovf = 1'b1;
            m_cnt = (m_cnt + 1) % VEC_LEN;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; s_valid = 1'b0; ovf_in = 1'b0;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; s_valid = 1'b0; m_ready = 1'b0; ovf_in = 1'b0; data_in = '0;
      step();
      step();
      reset = 1'b0;
      for (int i = 0; i < NI; i++) begin
         n_vec++;
         if (m_valid[i] !== 1'b0 || s_ready[i] !== 1'b1 || data_out[i] !== 8'h00 ||
             m_last[i] !== 1'b0 || overflow[i] !== 1'b0 || sat[i] !== 1'b0) begin
            n_err++;
            $display("FAIL reset inst%0d got v=%b r=%b d=%h l=%b o=%b s=%b exp v=0 r=1 d=00 l=0 o=0 s=0",
                     i, m_valid[i], s_ready[i], data_out[i], m_last[i], overflow[i], sat[i]);
         end
      end
   endtask

   task automatic test_basic();
      int  vin  [3] = '{291, 24, 23};
      int  vexp [3] = '{18, 2, 1};
      m_ready = 1'b1; s_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         data_in = 16'(vin[k]);
         step();
         n_vec++;
         if (m_valid[0] !== 1'b1 || data_out[0] !== 8'(vexp[k]) || m_last[0] !== (k == 2)) begin
            n_err++;
            $display("FAIL basic elem%0d got v=%b d=%0d l=%b exp v=1 d=%0d l=%b",
                     k, m_valid[0], $signed(data_out[0]), m_last[0], vexp[k], k == 2);
         end
      end
      n_vec++;
      if (overflow[0] !== 1'b0 || sat[0] !== 1'b0) begin
         n_err++;
         $display("FAIL basic_flags got o=%b s=%b exp o=0 s=0", overflow[0], sat[0]);
      end
      s_valid = 1'b0;
      step();
   endtask

   task automatic test_relu_sat();
      int vin [4] = '{-50, 3000, 100, -32768};
      int ea  [4] = '{0, 127, 6, 0};
      int eb  [4] = '{-3, 127, 6, -128};
      m_ready = 1'b1; s_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         data_in = 16'(vin[k]);
         step();
         n_vec++;
         if (data_out[0] !== 8'(ea[k]) || data_out[1] !== 8'(eb[k])) begin
            n_err++;
            $display("FAIL relu_sat in=%0d got relu=%0d norelu=%0d exp relu=%0d norelu=%0d",
                     vin[k], $signed(data_out[0]), $signed(data_out[1]), ea[k], eb[k]);
         end
         n_vec++;
         if (sat[0] !== (k >= 1) || sat[1] !== (k >= 1)) begin
            n_err++;
            $display("FAIL sat_sticky in=%0d got %b/%b exp %b", vin[k], sat[0], sat[1], k >= 1);
         end
      end
      s_valid = 1'b0;
      step();
   endtask

   task automatic test_backpressure();
      int vals [5] = '{10, 20, 30, 40, 50};
      int tail [4] = '{20, 30, 40, 50};
      s_valid = 1'b0; m_ready = 1'b1;
      step(); step();
      m_ready = 1'b0; s_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         data_in = 16'(vals[k]);
         step();
         n_vec++;
         if (s_ready[2] !== (k < 3)) begin
            n_err++;
            $display("FAIL bp_fill k=%0d got s_ready=%b exp %b", k, s_ready[2], k < 3);
         end
      end
      data_in = 16'(vals[4]);
      for (int k = 0; k < 3; k++) begin
         step();
         n_vec++;
         if (s_ready[2] !== 1'b0 || m_valid[2] !== 1'b1 || data_out[2] !== 8'd10) begin
            n_err++;
            $display("FAIL bp_stall cyc%0d got r=%b v=%b d=%0d exp r=0 v=1 d=10",
                     k, s_ready[2], m_valid[2], data_out[2]);
         end
      end
      m_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         if (k == 1) s_valid = 1'b0;
         n_vec++;
         if (m_valid[2] !== 1'b1 || data_out[2] !== 8'(tail[k])) begin
            n_err++;
            $display("FAIL bp_drain k=%0d got v=%b d=%0d exp v=1 d=%0d",
                     k, m_valid[2], data_out[2], tail[k]);
         end
      end
      step();
      n_vec++;
      if (m_valid[2] !== 1'b0) begin
         n_err++;
         $display("FAIL bp_empty got v=%b exp 0", m_valid[2]);
      end
   endtask

   task automatic test_tagging();
      do_reset();
      m_ready = 1'b1; s_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         data_in = 16'(k * 16);
         step();
         n_vec++;
         if (m_last[0] !== (k % 3 == 2) || data_out[0] !== 8'(k)) begin
            n_err++;
            $display("FAIL tag elem%0d got l=%b d=%0d exp l=%b d=%0d",
                     k + 1, m_last[0], data_out[0], k % 3 == 2, k);
         end
      end
      s_valid = 1'b0;
      step();
   endtask

   task automatic test_overflow();
      int vin  [3] = '{100, 200, 300};
      int vexp [3] = '{6, 13, 19};
      do_reset();
      m_ready = 1'b1; s_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         data_in = 16'(vin[k]);
         ovf_in  = (k == 1);
         step();
         n_vec++;
         if (overflow[0] !== (k >= 1) || data_out[0] !== 8'(vexp[k])) begin
            n_err++;
            $display("FAIL ovf elem%0d got o=%b d=%0d exp o=%b d=%0d",
                     k, overflow[0], data_out[0], k >= 1, vexp[k]);
         end
      end
      s_valid = 1'b0; ovf_in = 1'b0; m_ready = 1'b0;
      step(); step();
      n_vec++;
      if (overflow[0] !== 1'b1 || overflow[2] !== 1'b1) begin
         n_err++;
         $display("FAIL ovf_sticky got %b/%b exp 1", overflow[0], overflow[2]);
      end
   endtask

   task automatic test_reset_midstream();
      bit mr [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      do_reset();
      s_valid = 1'b1; data_in = 16'd5000;
      for (int k = 0; k < 5; k++) begin
         m_ready = mr[k];
         ovf_in  = (k == 0);
         step();
      end
      ovf_in = 1'b0;
      n_vec++;
      if (m_valid[0] !== 1'b1 || overflow[0] !== 1'b1 || sat[0] !== 1'b1) begin
         n_err++;
         $display("FAIL mid_pre got v=%b o=%b s=%b exp 1 1 1", m_valid[0], overflow[0], sat[0]);
      end
      do_reset();
      for (int i = 0; i < NI; i++) begin
         n_vec++;
         if (m_valid[i] !== 1'b0 || s_ready[i] !== 1'b1 || overflow[i] !== 1'b0 || sat[i] !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset inst%0d got v=%b r=%b o=%b s=%b exp 0 1 0 0",
                     i, m_valid[i], s_ready[i], overflow[i], sat[i]);
         end
      end
      m_ready = 1'b1; s_valid = 1'b1; data_in = 16'd64;
      for (int k = 0; k < 3; k++) begin
         step();
         n_vec++;
         if (m_last[0] !== (k == 2)) begin
            n_err++;
            $display("FAIL mid_tag elem%0d got l=%b exp %b", k, m_last[0], k == 2);
         end
      end
      s_valid = 1'b0;
      step();
   endtask

   task automatic test_random();
      int e;
      for (int c = 0; c < 600; c++) begin
         reset   = ($urandom_range(0, 79) == 0);
         s_valid = ($urandom_range(0, 3) != 0);
         m_ready = ($urandom_range(0, 2) != 0);
         ovf_in  = ($urandom_range(0, 31) == 0);
         data_in = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($signed($urandom_range(0, 4000)) - 2000);
         step();
         for (int i = 0; i < NI; i++) begin
            n_vec++;
            if (s_ready[i] !== (mq[i].size() < DEPTH) || m_valid[i] !== (mq[i].size() > 0)) begin
               n_err++;
               $display("FAIL rand_hs inst%0d cyc%0d got r=%b v=%b exp r=%b v=%b", i, c,
                        s_ready[i], m_valid[i], mq[i].size() < DEPTH, mq[i].size() > 0);
            end
            if (mq[i].size() > 0) begin
               e = mq[i][0];
               n_vec++;
               if (data_out[i] !== e[7:0] || m_last[i] !== e[8]) begin
                  n_err++;
                  $display("FAIL rand_data inst%0d cyc%0d got d=%h l=%b exp d=%h l=%b",
                           i, c, data_out[i], m_last[i], e[7:0], e[8]);
               end
            end
            n_vec++;
            if (overflow[i] !== m_ovf || sat[i] !== m_sat[i]) begin
               n_err++;
               $display("FAIL rand_flags inst%0d cyc%0d got o=%b s=%b exp o=%b s=%b",
                        i, c, overflow[i], sat[i], m_ovf, m_sat[i]);
            end
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      m_cnt = 0;
      m_ovf = 1'b0;
      for (int i = 0; i < NI; i++) m_sat[i] = 1'b0;
      test_reset();
      test_basic();
      test_relu_sat();
      test_backpressure();
      test_tagging();
      test_overflow();
      test_reset_midstream();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired before the bench completed");
      $fatal(1, "watchdog");
   end
endmodule
